serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 15 +
 rtl/serial_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_subtractor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: D = A - B - Bin, Bout set when the bit borrows.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  always_comb begin
    D    = A ^ B ^ Bin;
    Bout = (~A & B) | (~(A ^ B) & Bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per cycle LSB-first, result registered on completion.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Z
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             z_q, z_d;

  logic             fs_d;
  logic             fs_bout;

  full_subtractor u_full_subtractor (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Bin  (br_q),
    .D    (fs_d),
    .Bout (fs_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    d_d     = d_q;
    bout_d  = bout_q;
    z_d     = z_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        res_d = {fs_d, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = fs_bout;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = DONE;
        end
      end
      DONE: begin
        d_d     = res_q;
        bout_d  = br_q;
        z_d     = (res_q == '0);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      z_q     <= z_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes model results, monitor checks on done.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
  logic         Z;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [W+1:0] exp_q[$];   // {D, Bout, Z}
  int           exp_cyc_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .Z     (Z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic bin);
    longint       diff;
    logic [W-1:0] dv;
    diff = longint'(a) - longint'(b) - longint'(bin);
    dv   = diff[W-1:0];
    return {dv, diff < 0, dv == '0};
  endfunction

  // Monitor: pops on every done, otherwise demands outputs hold the last result.
  initial begin : monitor
    logic [W+1:0] hold;
    logic [W+1:0] e;
    int           ec;
    hold = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = '0;
        exp_q.delete();
        exp_cyc_q.delete();
      end else if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: got done=1 expected done=0 at cycle %0d", cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk("result", {D, Bout, Z}, e);
          chk("latency", cyc, ec);
          hold = e;
        end
      end else begin
        chk("hold", {D, Bout, Z}, hold);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now("issue_wait");
    A     = a;
    B     = b;
    Bin   = bin;
    start = 1'b1;
    exp_q.push_back(model(a, b, bin));
    exp_cyc_q.push_back(cyc + int'(W) + 2);
    @(negedge clk);
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    Bin   = 1'($urandom);
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) fail_now("drain");
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_D", D, '0);
    chk("rst_Bout", Bout, 1'b0);
    chk("rst_Z", Z, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, back-to-back.
    issue(8'h5A, 8'h3C, 1'b0);
    issue(8'h00, 8'h01, 1'b0);
    issue(8'h80, 8'h7F, 1'b1);
    issue(8'h33, 8'h33, 1'b0);
    issue(8'h00, 8'hFF, 1'b1);
    drain();

    // Starts while busy are ignored.
    issue(8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    A = 8'hFF; B = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 8'hFF; B = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset mid-operation abandons it.
    issue(8'hC3, 8'h12, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_D", D, '0);
    chk("midrst_Bout", Bout, 1'b0);
    chk("midrst_Z", Z, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_done_D", D, '0);
    issue(8'h10, 8'h01, 1'b0);
    drain();

    // Random operands with random gaps between operations.
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
